// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES-128 definitions: FSM encodings, S-box table, xtime and round constants.
// Byte order: byte 0 sits at [127:120]; bytes fill columns first (4 bytes per column).
package aes128_enc_iter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b starts at bit 2047-8*b, i.e. {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return C_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes128_enc_iter_key_step.sv
// One AES-128 key-schedule step: rk -> next round key, combinational.
module aes_key_step
  import aes128_enc_iter_pkg::*;
(
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_rk_next
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_rk;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_t   = w_sub ^ {i_rcon, 24'h000000};

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_rk_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_enc_iter_sbytes.sv
// SubBytes over a full 128-bit state, purely combinational.
module SBytes
  import aes128_enc_iter_pkg::*;
(
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);

  for (genvar g = 0; g < 16; g++) begin : g_byte
    assign o_data[8*g +: 8] = sbox(i_data[8*g +: 8]);
  end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
module aes128_enc_iter
  import aes128_enc_iter_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  localparam logic [3:0] C_LAST = 4'(NR);

  logic [1:0]   r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_state;
  logic [127:0] r_rk;

  logic [127:0] w_sb, w_sr, w_mc, w_rk_next;
  logic [7:0]   w_rcon;

  // Output byte (row r, col c) takes input byte (row r, col (c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

  SBytes u_sbytes (
    .i_data (r_state),
    .o_data (w_sb)
  );

  assign w_rcon = rcon(r_rnd);

  aes_key_step u_key_step (
    .i_rk      (r_rk),
    .i_rcon    (w_rcon),
    .o_rk_next (w_rk_next)
  );

  assign w_sr = shift_rows(w_sb);
  assign w_mc = mix_columns(w_sr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_rnd   <= '0;
      r_state <= '0;
      r_rk    <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= plaintext ^ key;
            r_rk    <= key;
            r_rnd   <= 4'd1;
            r_fsm   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_rk  <= w_rk_next;
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == C_LAST) begin
            r_state <= w_sr ^ w_rk_next;
            r_fsm   <= ST_DONE;
          end else begin
            r_state <= w_mc ^ w_rk_next;
          end
        end
        ST_DONE: begin
          if (out_ready) r_fsm <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_fsm == ST_IDLE);
  assign out_valid  = (r_fsm == ST_DONE);
  assign ciphertext = r_state;

endmodule
